// File: rtl/ysyx_22050612_mem_arbiter.sv
// Two-requester arbiter in front of a single handshaked memory port.
// LSU has priority; the streak counter forces the IFU through after LSU_STREAK_MAX LSU wins.
module ysyx_22050612_mem_arbiter #(
    parameter int AW             = 64,
    parameter int DW             = 64,
    parameter int LSU_STREAK_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_resp_valid,
    output logic [DW-1:0]   ifu_rdata,

    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_addr,
    input  logic            lsu_wen,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wmask,
    output logic            lsu_resp_valid,
    output logic [DW-1:0]   lsu_rdata,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wen,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [DW-1:0]   mem_rdata,

    output logic [1:0]      dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and request fields stay stable while valid waits.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic       OWN_IFU    = 1'b0;
    localparam logic       OWN_LSU    = 1'b1;
    localparam logic [3:0] STREAK_MAX = 4'(LSU_STREAK_MAX);

    state_t     state;
    state_t     state_nxt;
    logic       owner;
    logic [3:0] streak;
    logic       grant_ifu;
    logic       grant_lsu;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_ifu || grant_lsu) state_nxt = S_REQ;
            S_REQ:   if (mem_req_ready) state_nxt = S_RESP;
            S_RESP:  if (mem_resp_valid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // LSU wins ties unless the IFU has already been passed over STREAK_MAX times.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state == S_IDLE) begin
            if (lsu_req_valid && !(ifu_req_valid && (streak >= STREAK_MAX))) begin
                grant_lsu = 1'b1;
            end else if (ifu_req_valid) begin
                grant_ifu = 1'b1;
            end
        end
        ifu_req_ready = grant_ifu;
        lsu_req_ready = grant_lsu;
        mem_req_valid = (state == S_REQ);
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            streak         <= 4'd0;
            owner          <= OWN_IFU;
            mem_addr       <= '0;
            mem_wen        <= 1'b0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            lsu_rdata      <= '0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;

            if (grant_lsu) begin
                if (ifu_req_valid) begin
                    streak <= (streak >= STREAK_MAX) ? streak : streak + 4'd1;
                end else begin
                    streak <= 4'd0;
                end
                owner     <= OWN_LSU;
                mem_addr  <= lsu_addr;
                mem_wen   <= lsu_wen;
                mem_wdata <= lsu_wdata;
                mem_wmask <= lsu_wmask;
            end else if (grant_ifu) begin
                streak    <= 4'd0;
                owner     <= OWN_IFU;
                mem_addr  <= ifu_addr;
                mem_wen   <= 1'b0;
                mem_wdata <= '0;
                mem_wmask <= '0;
            end

            // Response data only lands in the owner's register; the other side holds.
            if ((state == S_RESP) && mem_resp_valid) begin
                if (owner == OWN_LSU) begin
                    lsu_resp_valid <= 1'b1;
                    lsu_rdata      <= mem_rdata;
                end else begin
                    ifu_resp_valid <= 1'b1;
                    ifu_rdata      <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Scoreboard bench for the IFU/LSU memory arbiter: drivers push expectations on accept,
// monitors pop them on mem handshakes and response pulses; a small memory model answers requests.
module tb_ysyx_22050612_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = DW / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    // ---------------- DUT ----------------
    logic          ifu_req_valid = 1'b0;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_addr = '0;
    logic          ifu_resp_valid;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid = 1'b0;
    logic          lsu_req_ready;
    logic [AW-1:0] lsu_addr = '0;
    logic          lsu_wen = 1'b0;
    logic [DW-1:0] lsu_wdata = '0;
    logic [MW-1:0] lsu_wmask = '0;
    logic          lsu_resp_valid;
    logic [DW-1:0] lsu_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [1:0]    dbg_state;

    ysyx_22050612_mem_arbiter #(.AW(AW), .DW(DW), .LSU_STREAK_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mem_model(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_0000) return 64'h0000_0000_0010_0073;
        return {a[31:0] ^ 32'hA5A5_5A5A, a[63:32] + 32'h0000_1234};
    endfunction

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
    } mem_req_t;

    mem_req_t      mem_exp_q[$];
    logic [DW-1:0] ifu_exp_q[$];
    logic [DW-1:0] lsu_exp_q[$];
    bit            lsu_wr_q[$];
    logic [7:0]    grant_log[$];

    logic [DW-1:0] ifu_rdata_exp  = '0;
    logic [DW-1:0] lsu_rdata_exp  = '0;
    bit            lsu_rdata_known = 1'b1;
    int            ifu_acc_cyc = 0;
    int            ifu_lat     = 0;
    int            lsu_resp_cnt = 0;

    // ---------------- memory model ----------------
    int            req_delay  = 0;
    int            resp_delay = 0;
    bit            spurious   = 1'b0;
    int            hs_count   = 0;
    logic [AW-1:0] hs_addr    = '0;

    int            hs_seen     = 0;
    bit            resp_pending = 1'b0;
    int            resp_cnt    = 0;
    int            wait_cycles = 0;
    logic [DW-1:0] resp_data   = '0;

    always @(posedge clk) begin
        #1;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        if (rst) begin
            resp_pending = 1'b0;
            hs_seen      = hs_count;
            wait_cycles  = 0;
        end else begin
            if (hs_seen != hs_count) begin
                hs_seen      = hs_count;
                resp_pending = 1'b1;
                resp_cnt     = resp_delay;
                resp_data    = mem_model(hs_addr);
                wait_cycles  = 0;
            end
            if (resp_pending) begin
                if (resp_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = resp_data;
                    resp_pending   = 1'b0;
                end else begin
                    resp_cnt--;
                end
            end else if (spurious) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            if (mem_req_valid) begin
                if (wait_cycles >= req_delay) mem_req_ready = 1'b1;
                else wait_cycles++;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req_valid) begin
                check("mem_req_expected", 64'(mem_exp_q.size() != 0), 64'd1);
                if (mem_exp_q.size() != 0) begin
                    check("mem_addr", mem_addr, mem_exp_q[0].addr);
                    check("mem_wen", 64'(mem_wen), 64'(mem_exp_q[0].wen));
                    check("mem_wmask", 64'(mem_wmask), 64'(mem_exp_q[0].wmask));
                    if (mem_exp_q[0].wen) check("mem_wdata", mem_wdata, mem_exp_q[0].wdata);
                    if (mem_req_ready) void'(mem_exp_q.pop_front());
                end
                if (mem_req_ready) begin
                    hs_addr  = mem_addr;
                    hs_count = hs_count + 1;
                end
            end
            if (ifu_resp_valid) begin
                check("ifu_resp_expected", 64'(ifu_exp_q.size() != 0), 64'd1);
                if (ifu_exp_q.size() != 0) begin
                    ifu_rdata_exp = ifu_exp_q.pop_front();
                    check("ifu_rdata", ifu_rdata, ifu_rdata_exp);
                    ifu_lat = cyc - ifu_acc_cyc;
                end
            end
            if (lsu_resp_valid) begin
                lsu_resp_cnt = lsu_resp_cnt + 1;
                check("lsu_resp_expected", 64'(lsu_exp_q.size() != 0), 64'd1);
                if (lsu_exp_q.size() != 0) begin
                    lsu_rdata_exp = lsu_exp_q.pop_front();
                    lsu_rdata_known = !lsu_wr_q.pop_front();
                    if (lsu_rdata_known) check("lsu_rdata", lsu_rdata, lsu_rdata_exp);
                end
            end
        end
    end

    // ---------------- drivers (called at posedge+1) ----------------
    task automatic ifu_issue(input logic [AW-1:0] addr);
        bit done = 1'b0;
        int budget = 300;
        mem_req_t m;
        ifu_addr      = addr;
        ifu_req_valid = 1'b1;
        while (!done && budget > 0) begin
            @(negedge clk);
            budget--;
            if (ifu_req_ready) begin
                done = 1'b1;
                check("excl_ready_lsu", 64'(lsu_req_ready), 64'd0);
                check("ready_in_idle", 64'(dbg_state), 64'(ST_IDLE));
                m.addr = addr; m.wen = 1'b0; m.wdata = '0; m.wmask = '0;
                mem_exp_q.push_back(m);
                ifu_exp_q.push_back(mem_model(addr));
                grant_log.push_back(8'h49);
                ifu_acc_cyc = cyc;
            end
        end
        check("ifu_accept", 64'(done), 64'd1);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
    endtask

    task automatic lsu_issue(input logic [AW-1:0] addr, input logic wen,
                             input logic [DW-1:0] wdata, input logic [MW-1:0] wmask);
        bit done = 1'b0;
        int budget = 300;
        mem_req_t m;
        lsu_addr = addr; lsu_wen = wen; lsu_wdata = wdata; lsu_wmask = wmask;
        lsu_req_valid = 1'b1;
        while (!done && budget > 0) begin
            @(negedge clk);
            budget--;
            if (lsu_req_ready) begin
                done = 1'b1;
                check("excl_ready_ifu", 64'(ifu_req_ready), 64'd0);
                check("ready_in_idle", 64'(dbg_state), 64'(ST_IDLE));
                m.addr = addr; m.wen = wen; m.wdata = wdata; m.wmask = wmask;
                mem_exp_q.push_back(m);
                lsu_exp_q.push_back(wen ? '0 : mem_model(addr));
                lsu_wr_q.push_back(wen);
                grant_log.push_back(8'h4C);
            end
        end
        check("lsu_accept", 64'(done), 64'd1);
        @(posedge clk); #1;
        lsu_req_valid = 1'b0;
    endtask

    task automatic ifu_stream(input int n);
        for (int i = 0; i < n; i++) begin
            ifu_issue(64'h8000_4000 + 64'($urandom_range(0, 1023)) * 4);
        end
    endtask

    task automatic lsu_stream(input int n);
        logic wen;
        for (int i = 0; i < n; i++) begin
            wen = 1'($urandom_range(0, 1));
            lsu_issue(64'h8001_0000 + 64'($urandom_range(0, 1023)) * 8, wen,
                      {$urandom, $urandom}, wen ? 8'($urandom_range(1, 255)) : 8'h00);
        end
    endtask

    task automatic set_mem(input int rq, input int rs, input bit sp);
        req_delay  = rq;
        resp_delay = rs;
        spurious   = sp;
    endtask

    // Waits for every outstanding expectation to drain, then realigns to posedge+1.
    task automatic wait_idle();
        int budget = 500;
        while ((ifu_exp_q.size() + lsu_exp_q.size() + mem_exp_q.size()) != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("drain", 64'(ifu_exp_q.size() + lsu_exp_q.size() + mem_exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_hold();
        check("ifu_rdata_hold", ifu_rdata, ifu_rdata_exp);
        if (lsu_rdata_known) check("lsu_rdata_hold", lsu_rdata, lsu_rdata_exp);
    endtask

    task automatic check_order(input string exp_order);
        check("grant_count", 64'(grant_log.size()), 64'(exp_order.len()));
        for (int i = 0; i < exp_order.len(); i++) begin
            check("grant_order", 64'(grant_log[i]), 64'(exp_order[i]));
        end
        grant_log.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
        check({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
        check({tag, "_mem_addr"}, mem_addr, 64'd0);
        check({tag, "_mem_wen"}, 64'(mem_wen), 64'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        check({tag, "_mem_wmask"}, 64'(mem_wmask), 64'd0);
        check({tag, "_ifu_resp_valid"}, 64'(ifu_resp_valid), 64'd0);
        check({tag, "_lsu_resp_valid"}, 64'(lsu_resp_valid), 64'd0);
        check({tag, "_ifu_rdata"}, ifu_rdata, 64'd0);
        check({tag, "_lsu_rdata"}, lsu_rdata, 64'd0);
    endtask

    // ---------------- test sequence ----------------
    int budget;
    int lsu_cnt0;

    initial begin
        set_mem(0, 0, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // IFU alone: minimum latency and the canonical fetch data.
        ifu_issue(64'h8000_0000);
        @(negedge clk);
        check("t1_mem_req_valid", 64'(mem_req_valid), 64'd1);
        check("t1_state_req", 64'(dbg_state), 64'(ST_REQ));
        @(posedge clk); #1;
        wait_idle();
        check("t1_latency", 64'(ifu_lat), 64'd3);
        check("t1_ifu_rdata", ifu_rdata, 64'h0000_0000_0010_0073);
        grant_log.delete();

        // LSU write with memory back-pressure; monitor checks mem_* every stalled cycle.
        set_mem(5, 0, 1'b0);
        lsu_cnt0 = lsu_resp_cnt;
        lsu_issue(64'h8000_1004, 1'b1, 64'hDEAD_BEEF_0000_0000, 8'hF0);
        wait_idle();
        repeat (3) @(posedge clk); #1;
        check("t2_lsu_pulses", 64'(lsu_resp_cnt - lsu_cnt0), 64'd1);
        check_hold();
        grant_log.delete();

        // Both valid continuously: IFU forced through after four LSU grants, twice.
        set_mem(0, 0, 1'b0);
        fork
            ifu_stream(2);
            lsu_stream(9);
        join
        wait_idle();
        check_order("LLLLILLLLIL");
        check_hold();

        // Simultaneous single requests with streak at zero.
        fork
            ifu_issue(64'h8000_0100);
            lsu_issue(64'h8000_2008, 1'b0, 64'd0, 8'h00);
        join
        wait_idle();
        check_order("LI");
        check_hold();

        // Reset lands on the same edge as the memory response.
        set_mem(0, 1, 1'b0);
        ifu_issue(64'h8000_0200);
        budget = 20;
        while (!mem_resp_valid && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("t5_resp_seen", 64'(mem_resp_valid), 64'd1);
        check("t5_state_resp", 64'(dbg_state), 64'(ST_RESP));
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("t5_after_reset");
        ifu_exp_q.delete();
        lsu_exp_q.delete();
        lsu_wr_q.delete();
        mem_exp_q.delete();
        grant_log.delete();
        ifu_rdata_exp   = '0;
        lsu_rdata_exp   = '0;
        lsu_rdata_known = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        set_mem(0, 0, 1'b0);
        ifu_issue(64'h8000_0300);
        wait_idle();
        check("t5_ifu_rdata_after", ifu_rdata, mem_model(64'h8000_0300));
        check_hold();

        // Spurious memory responses in IDLE and REQ must be ignored.
        set_mem(3, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_idle_state", 64'(dbg_state), 64'(ST_IDLE));
        end
        @(posedge clk); #1;
        ifu_issue(64'h8000_0400);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_req_state", 64'(dbg_state), 64'(ST_REQ));
        end
        @(posedge clk); #1;
        wait_idle();
        set_mem(0, 0, 1'b0);
        check_hold();
        grant_log.delete();

        // Random mix with random memory timing.
        set_mem($urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
        fork
            ifu_stream(5);
            lsu_stream(5);
        join
        wait_idle();
        check_hold();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ysyx_22050612_mem_arbiter.md
Name: ysyx_22050612_mem_arbiter

Overview:
Shares the single pmem access port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write), so that the core can move from same-cycle DPI memory access to a handshaked, multi-cycle memory.
- Arbitrates between the two requesters with LSU priority and a bounded-starvation counter for the IFU.
- Latches the winning request and drives it to memory with a valid/ready handshake.
- Routes the response back to the owner.
- Allows exactly one outstanding transaction.

Parameters:
- AW, 64: address width.
- DW, 64: data width; the mask width is DW/8.
- LSU_STREAK_MAX, 4: consecutive LSU grants allowed while the IFU is waiting before the IFU is forced through (range 1..15).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  AW  IFU read address.
- ifu_resp_valid  out  1  one-cycle pulse: ifu_rdata valid.
- ifu_rdata  out  DW  IFU read data.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  AW  LSU address.
- lsu_wen  in  1  1 = write, 0 = read.
- lsu_wdata  in  DW  write data.
- lsu_wmask  in  DW/8  byte write mask.
- lsu_resp_valid  out  1  one-cycle pulse: read data valid or write done.
- lsu_rdata  out  DW  LSU read data.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  AW  latched address.
- mem_wen  out  1  latched write enable.
- mem_wdata  out  DW  latched write data.
- mem_wmask  out  DW/8  latched write mask.
- mem_resp_valid  in  1  memory response.
- mem_rdata  in  DW  memory read data.

Behaviour:
- **States:** IDLE, REQ, RESP. The owner register is IFU or LSU. The streak counter is 4 bits and saturates at LSU_STREAK_MAX.
- **Reset:**
  - state = IDLE, streak = 0, owner = IFU.
  - All mem_* outputs = 0.
  - *_resp_valid = 0 and *_rdata = 0.
  - Reset during REQ or RESP abandons the transaction; no response pulse is issued.
- **IDLE grant (combinational):**
  - Only one valid: grant it.
  - Both valid: grant LSU unless streak == LSU_STREAK_MAX, in which case grant IFU.
  - Neither valid: stay in IDLE.
  - ifu_req_ready = (state == IDLE) && grant_ifu; lsu_req_ready is the same for LSU. Ready is never asserted outside IDLE.
- **Streak counter:**
  - On an LSU grant while ifu_req_valid = 1: streak increments (saturating).
  - On an LSU grant with no IFU waiting: streak = 0.
  - On an IFU grant: streak = 0.
- **Request latch:** on a grant at edge N, latch addr, wen, wdata, wmask and owner, and go to REQ. mem_req_valid = 1 from cycle N+1.
  - An IFU grant latches wen = 0 and wmask = 0.
- **REQ:**
  - mem_req_valid and mem_* stay stable until mem_req_ready = 1. Then go to RESP and drop mem_req_valid the next cycle.
  - mem_resp_valid is ignored in REQ.
- **RESP:** wait for mem_resp_valid = 1. On that edge:
  - Register mem_rdata into the owner's *_rdata.
  - Pulse the owner's *_resp_valid for exactly one cycle, in the next cycle.
  - Return to IDLE.
- **Turnaround:** a new grant is possible in the same cycle the resp pulse is visible (state is IDLE).
  - Minimum request-to-response latency is 3 cycles with mem_req_ready = 1 and a one-cycle memory response.
- **Data outputs:**
  - *_rdata holds its value until that owner's next response.
  - A write response updates lsu_rdata with mem_rdata (don't-care content); the bench must not check it.
  - The non-owner's resp_valid and rdata never change.
- **Wrap-around:** the streak counter never wraps; it saturates.

Test Plan:
1. IFU only, addr 0x80000000, mem ready immediately, response next cycle with rdata 0x00100073 → ifu_req_ready at cycle 0, mem_req_valid at 1, ifu_resp_valid pulse at 3, ifu_rdata = 0x00100073.
2. LSU write, addr 0x80001004, wdata 0xDEADBEEF00000000, wmask 0xF0, mem_req_ready held low 5 cycles → mem_* stable all 5 cycles; exactly one lsu_resp_valid pulse; ifu_resp_valid stays 0.
3. Both valid continuously, LSU_STREAK_MAX = 4 → grant order LSU, LSU, LSU, LSU, IFU, LSU…; streak resets after the IFU grant.
4. Both valid on the same cycle once (streak = 0) → LSU granted, ifu_req_ready = 0; IFU is granted at the next IDLE after the LSU response if the LSU has dropped its request.
5. Reset asserted in RESP with mem_resp_valid arriving in the reset cycle → no resp pulse; all outputs 0 the next cycle; a new IFU request is served normally afterwards.
6. Spurious mem_resp_valid = 1 in IDLE and in REQ → ignored; no resp pulse; state unchanged.
